fir_sample_fifo: RTL and testbench
==================================

# fir_sample_fifo

Output sample buffer directly downstream of the AXI-lite FIR filter. Captures every `valid_out`/`data_out` pulse from the filter, which has no backpressure, into a first-word-fall-through FIFO. Presents the samples on a valid/ready stream to the next consumer (DMA, DAC or decimator). Overflow drops the new sample and is reported via a sticky flag and a saturating drop counter.

## Interface
- `DATA_W`, default 16: sample width (Q1.15 from the filter).
- `DEPTH`, default 16: number of entries; power of two, ≥ 2.
- `CNT_W`, default 16: drop counter width.

- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: synchronous, active-high reset, sampled on `clk` rising edge.
- `in_valid`  in  1: sample strobe, connected to the filter's `valid_out`.
- `in_data`  in  DATA_W: sample, connected to the filter's `data_out`.
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_data`  out  DATA_W: head entry; forced to 0 while `out_valid`=0.
- `level`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full`  out  1: `level`==DEPTH.
- `overflow`  out  1: sticky; set when a sample is dropped.
- `drop_count`  out  CNT_W: dropped samples; saturates at all-ones.
- `clr_overflow`  in  1: single-cycle clear of `overflow` and `drop_count`.

## Operation
- Storage: DEPTH×DATA_W register array. Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a `level` counter, not derived from the pointers.
- Push = `in_valid` && (!`full` || pop). Pop = `out_valid` && `out_ready`.
- On push: write `mem[wr_ptr]` ← `in_data` and increment `wr_ptr`. On pop: increment `rd_ptr`.
- `level` next value: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Full with simultaneous pop: the write is accepted and `level` stays at DEPTH. No drop occurs.
- Empty: a pop cannot occur. An incoming sample is written and is not bypassed to the output in the same cycle.
- Drop = `in_valid` && `full` && !pop. On a drop:
  - the sample is discarded and memory and pointers are unchanged;
  - `overflow` ← 1;
  - `drop_count` increments, holding at 2^CNT_W−1.
- `clr_overflow`: `overflow` ← 0 and `drop_count` ← 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow`=1 and `drop_count`=1.
- `out_valid` = (`level` != 0). `out_data` = `mem[rd_ptr]` when `out_valid`, else 0.
- `out_data` holds stable while `out_valid` && !`out_ready`.
- Reset (any cycle, including mid-stream):
  - pointers, `level`, `overflow` and `drop_count` go to 0;
  - memory contents are not cleared;
  - `in_valid` during the reset cycle is ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `level`=0, `full`=0, `overflow`=0, `drop_count`=0.
- Write latency: a sample pushed at edge N appears with `out_valid`=1 and correct `out_data` after edge N (visible in cycle N+1).
- `level`, `full`, `overflow` and `drop_count` are registered and update on the same edge as the push, pop or drop that causes them.
- Pop takes effect on the edge where `out_valid` && `out_ready`. The next entry, or `out_valid`=0, is visible in the following cycle.
- Sustained throughput: one push and one pop per cycle, indefinitely, at any level.
- `out_ready` may be high while `out_valid`=0; this has no effect.
- No combinational path from `in_valid`/`in_data` to any output. `out_data` and `out_valid` depend only on registered state.

## Test plan
- Reset then idle: hold `rst` 3 cycles, then release with no traffic → all outputs stay 0 and `level`=0.
- Ordered pass-through: `out_ready`=1, push 0x7FFF, 0x8000, 0x2000 on consecutive cycles → `out_data` sequence 0x7FFF, 0x8000, 0x2000, each one cycle after its push. `level` never exceeds 1.
- Fill and overflow (DEPTH=16):
  - `out_ready`=0, push 0x0001..0x0012 (18 samples) → `full`=1, `level`=16, `overflow`=1, `drop_count`=2.
  - Then `out_ready`=1 → outputs 0x0001..0x0010 in order, then `out_valid`=0.
- Full with simultaneous push and pop: at `level`=16, assert `in_valid` (0xABCD) and `out_ready` together for 1 cycle → no drop and `level` stays 16. 0xABCD emerges as the 16th sample after the current head.
- Clear vs drop collision: with `drop_count`=5 and full, assert `clr_overflow` and a dropping `in_valid` in the same cycle → `overflow`=1, `drop_count`=1. A subsequent lone `clr_overflow` → both 0.
- Mid-stream reset and wrap: run 40 push/pop pairs (pointers wrap twice) with `level`=3, then pulse `rst` with `in_valid` high → next cycle `level`=0, `out_valid`=0. The next push after reset is the first sample output.

Source files
------------

// File: rtl/fir_sample_fifo.sv
// Output sample buffer behind the FIR filter: first-word-fall-through FIFO with
// drop-on-overflow, a sticky overflow flag and a saturating drop counter.
module fir_sample_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  input  logic                     clr_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  logic push, pop, drop;
  logic [DATA_W-1:0] head_next;

  // Handshake decode; full with a simultaneous pop still accepts the write.
  always_comb begin
    pop  = out_valid_q && out_ready;
    push = in_valid && (!full_q || pop);
    drop = in_valid && full_q && !pop;
  end

  // Next-state for pointers, occupancy, flags and the registered head word.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    if (clr_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
    // A drop in the same cycle as a clear wins and counts from zero.
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_d != {CNT_W{1'b1}}) drop_count_d = drop_count_d + CNT_W'(1);
    end

    full_d      = (level_d == LVL_W'(DEPTH));
    out_valid_d = (level_d != '0);

    // The next head may be the word being written this very cycle.
    if (push && (wr_ptr_q == rd_ptr_d)) head_next = in_data;
    else                                head_next = mem_q[rd_ptr_d];
    out_data_d = out_valid_d ? head_next : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Sample storage is never cleared; writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign level      = level_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Bench for fir_sample_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer.
module tb_fir_sample_fifo;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              clr_overflow = 1'b0;

  always #5 clk = ~clk;

  fir_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .full         (full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clr_overflow (clr_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the FIFO contents as an ordered list of samples.
  logic [DATA_W-1:0] mq[$];
  bit m_ovf = 1'b0;
  int m_dc  = 0;
  bit m_ok  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs to the model, drive inputs, advance the model.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r,
                      input bit c, input bit rs);
    bit pop, fl, drop, push;
    @(negedge clk);
    if (m_ok) begin
      check("out_valid",  32'(out_valid),  32'(mq.size() != 0));
      check("out_data",   32'(out_data),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check("level",      32'(level),      32'(mq.size()));
      check("full",       32'(full),       32'(mq.size() == DEPTH));
      check("overflow",   32'(overflow),   32'(m_ovf));
      check("drop_count", 32'(drop_count), 32'(m_dc));
    end
    rst = rs; in_valid = v; in_data = d; out_ready = r; clr_overflow = c;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
      m_ok  = 1'b1;
    end else begin
      pop  = (mq.size() != 0) && r;
      fl   = (mq.size() == DEPTH);
      drop = v && fl && !pop;
      push = v && (!fl || pop);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
      if (c) begin m_ovf = 1'b0; m_dc = 0; end
      if (drop) begin
        m_ovf = 1'b1;
        if (m_dc < CNT_MAX) m_dc++;
      end
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, '0, r, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + DATA_W'(i), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held three cycles, then idle
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    check("reset_level", 32'(level), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    idle(4, 1'b0);

    // Ordered pass-through with the consumer always ready
    step(1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    #1 check("pt_first", 32'(out_data), 32'h7FFF);
    step(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
    #1 check("pt_second", 32'(out_data), 32'h8000);
    step(1'b1, 16'h2000, 1'b1, 1'b0, 1'b0);
    #1 check("pt_third", 32'(out_data), 32'h2000);
    check("pt_level", 32'(level), 32'd1);
    idle(3, 1'b1);

    // Fill past capacity, then drain
    fill(18, 16'h0001);
    #1;
    check("fill_level", 32'(level), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd1);
    check("fill_drops", 32'(drop_count), 32'd2);
    idle(18, 1'b1);
    #1 check("drain_empty", 32'(out_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous push and pop
    fill(16, 16'h0100);
    step(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0);
    #1;
    check("fpp_level", 32'(level), 32'd16);
    check("fpp_nodrop", 32'(drop_count), 32'd0);
    idle(20, 1'b1);

    // Clear colliding with a drop
    fill(21, 16'h0200);
    #1 check("coll_pre", 32'(drop_count), 32'd5);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    #1;
    check("coll_ovf", 32'(overflow), 32'd1);
    check("coll_cnt", 32'(drop_count), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_cnt", 32'(drop_count), 32'd0);

    // Drop counter saturation
    fill(CNT_MAX + 5, 16'h0300);
    #1 check("sat_cnt", 32'(drop_count), 32'(CNT_MAX));
    idle(18, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Mid-stream reset after wrapping the pointers
    fill(3, 16'h0400);
    for (int i = 0; i < 40; i++) step(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0);
    #1 check("wrap_level", 32'(level), 32'd3);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    #1;
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    #1 check("mrst_first", 32'(out_data), 32'h5A5A);
    idle(2, 1'b1);

    // Random traffic with a range of consumer speeds
    for (int ph = 0; ph < 4; ph++) begin
      int rdy_pct;
      rdy_pct = 20 + ph * 27;
      for (int i = 0; i < 800; i++) begin
        step($urandom_range(0, 99) < 65,
             DATA_W'($urandom),
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 99) < 3,
             $urandom_range(0, 999) < 4);
      end
    end
    idle(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
